multibyte_add_seq: RTL and testbench
====================================

Name: multibyte_add_seq

Overview:
- Sequencer that performs a wide add or subtract on a single 8-bit adder slice.
- Processes one byte per clock, LSB first, and chains the carry through a register.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.
- One operation in flight at a time. Lets wide arithmetic reuse the team's 8-bit adder datapath instead of a full-width adder.

Parameters:
- NBYTES, 4, number of byte lanes per operand (minimum 1; operand width = 8*NBYTES).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept a request.
- in_a  in  8*NBYTES  operand A.
- in_b  in  8*NBYTES  operand B.
- in_sub  in  1  0 = A+B, 1 = A-B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  8*NBYTES  result.
- out_carry  out  1  carry out of MSB byte (for subtract: 1 = no borrow).
- out_ovf  out  1  signed two's-complement overflow.
- busy  out  1  high whenever not in IDLE.

Behaviour:
- Reset (asynchronous, immediate, any state):
  - State = IDLE, byte index = 0, carry reg = 0.
  - Operand/result registers = 0.
  - out_valid=0, out_sum=0, out_carry=0, out_ovf=0, busy=0, in_ready=1.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On rising edge with in_valid=1: capture in_a, in_b, in_sub; set carry reg = in_sub; byte index = 0; go to RUN.
- RUN:
  - in_ready=0.
  - Each edge, for byte k = index: bsel = in_sub ? ~B[k] : B[k]; {c, s} = A[k] + bsel + carry reg (9-bit result).
  - Write s to sum byte k; carry reg = c; index += 1.
  - On the edge processing k = NBYTES-1:
    - out_carry = c.
    - out_ovf = (A msb == bsel msb) && (s msb != A msb).
    - Go to DONE.
  - The index counter never exceeds NBYTES-1, with no wrap into a new operation.
- DONE:
  - out_valid=1; in_ready=0.
  - out_sum, out_carry and out_ovf are held stable until the handshake.
  - On edge with out_ready=1: go to IDLE, out_valid=0. out_sum stays at its last value.
- Latency: the accept edge is E0; out_valid rises after edge E(NBYTES).
- Throughput: minimum NBYTES+2 cycles per operation, because there is no accept in DONE.
- Captured operands are used throughout. Changes on in_a, in_b or in_sub after acceptance have no effect.
- in_valid is ignored outside IDLE. The requester holds it; it is not consumed.
- out_ready is ignored outside DONE.
- NBYTES=1: RUN lasts exactly one cycle.
- All arithmetic is modulo 2^(8*NBYTES). There are no X outputs after reset.

Test Plan:
All cases use NBYTES=4.
1. Add with byte carry propagation: A=0x000000FF, B=0x00000001, sub=0.
   - Expect out_sum=0x00000100, out_carry=0, out_ovf=0.
   - out_valid rises exactly 4 cycles after the accept edge.
2. Full-width wrap: A=0xFFFFFFFF, B=0x00000001, add.
   - Expect out_sum=0x00000000, out_carry=1, out_ovf=0.
   - Then A=0x7FFFFFFF, B=1: expect out_sum=0x80000000, out_ovf=1.
3. Subtract:
   - A=7, B=5: expect out_sum=0x00000002, out_carry=1.
   - A=5, B=7: expect out_sum=0xFFFFFFFE, out_carry=0, out_ovf=0.
   - A=0x80000000, B=1: expect out_ovf=1.
4. Backpressure: hold out_ready=0 for 3 cycles in DONE, with in_valid=1 and new operands applied.
   - Expect out_valid, out_sum, out_carry and out_ovf stable, in_ready=0, busy=1.
   - After out_ready=1, the next op is accepted on the first IDLE edge, and that result matches the new operands.
5. Operand change mid-RUN: change in_a and in_b after the accept edge.
   - Expect the result computed from the captured values only.
6. Reset mid-RUN: assert rst after byte 1 has been processed.
   - Expect immediate IDLE, out_valid=0, busy=0, in_ready=1.
   - After release, A=0x12345678 + B=0x11111111 gives out_sum=0x23456789, out_carry=0.

Source files
------------

// File: rtl/multibyte_add_seq.sv
// Wide add/subtract sequenced one byte per cycle through a single 8-bit adder slice.
// Latency: accept edge E0, result valid after edge E(NBYTES); at least NBYTES+2 cycles per op.
// Backpressure: no accept outside IDLE; the result is held in DONE until out_ready is seen.
module multibyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   in_a,
  input  logic [8*NBYTES-1:0]   in_b,
  input  logic                  in_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   out_sum,
  output logic                  out_carry,
  output logic                  out_ovf,
  output logic                  busy
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            sub_q, sub_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            oc_q, oc_d;
  logic            ov_q, ov_d;

  logic [7:0]      a_byte;
  logic [7:0]      b_byte;
  logic [7:0]      bsel;
  logic [8:0]      add9;

  // State, byte index, carry chain and operand/result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
      oc_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      sum_q   <= sum_d;
      oc_q    <= oc_d;
      ov_q    <= ov_d;
    end
  end

  // Byte-slice adder plus next-state logic; subtract is A + ~B + 1 with the 1 preloaded as carry-in
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    sum_d   = sum_q;
    oc_d    = oc_q;
    ov_d    = ov_q;
    a_byte  = 8'd0;
    b_byte  = 8'd0;

    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IW'(i)) begin
        a_byte = a_q[8*i +: 8];
        b_byte = b_q[8*i +: 8];
      end
    end
    bsel = sub_q ? ~b_byte : b_byte;
    add9 = {1'b0, a_byte} + {1'b0, bsel} + {8'd0, carry_q};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          sub_d   = in_sub;
          carry_d = in_sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IW'(i)) begin
            sum_d[8*i +: 8] = add9[7:0];
          end
        end
        carry_d = add9[8];
        if (idx_q == LAST) begin
          oc_d    = add9[8];
          ov_d    = (a_byte[7] == bsel[7]) && (add9[7] != a_byte[7]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = sum_q;
  assign out_carry = oc_q;
  assign out_ovf   = ov_q;

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Randomized and directed bench for multibyte_add_seq against a whole-word arithmetic model.
// Latency: checks out_valid arrives exactly NBYTES edges after accept.
// Backpressure: stalls in DONE with new operands offered and checks everything holds.
module tb_multibyte_add_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_sub = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_sum;
  logic          out_carry;
  logic          out_ovf;
  logic          busy;

  int n_chk  = 0;
  int n_pass = 0;

  multibyte_add_seq #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference: whole-word arithmetic on 64-bit integers, signs compared directly
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       output logic [W-1:0] s, output logic c, output logic v);
    logic [63:0] wide;
    if (sub) begin
      wide = {32'd0, a} - {32'd0, b};
      c    = (a >= b);
      s    = wide[W-1:0];
      v    = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
    end else begin
      wide = {32'd0, a} + {32'd0, b};
      c    = wide[W];
      s    = wide[W-1:0];
      v    = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    end
  endtask

  // One complete operation: offer, accept, wait result, optional stall, handshake
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input int stall, input bit scramble);
    logic [W-1:0] es;
    logic         ec, ev;
    logic [W-1:0] hs;
    logic         hc, hv;
    int           cyc;
    model(a, b, sub, es, ec, ev);
    @(negedge clk);
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'd1);
    if (scramble) begin
      in_a = $urandom; in_b = $urandom; in_sub = ~sub;
    end
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(NB));
    chk("sum", 64'(out_sum), 64'(es));
    chk("carry", 64'(out_carry), 64'(ec));
    chk("ovf", 64'(out_ovf), 64'(ev));
    hs = out_sum; hc = out_carry; hv = out_ovf;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_sub = $urandom_range(0, 1);
      @(posedge clk);
      #1;
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_sum", 64'(out_sum), 64'(hs));
      chk("stall_flags", {62'd0, out_carry, out_ovf}, {62'd0, hc, hv});
      chk("stall_rdy_busy", {62'd0, in_ready, busy}, {62'd0, 1'b0, 1'b1});
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_hs_valid", 64'(out_valid), 64'd0);
    chk("post_hs_ready", 64'(in_ready), 64'd1);
    chk("post_hs_sum_kept", 64'(out_sum), 64'(es));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    int sel;
    #12;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sum", 64'(out_sum), 64'd0);
    chk("rst_flags", {62'd0, out_carry, out_ovf}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases
    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0, 1'b0);
    chk("t1_sum_const", 64'(out_sum), 64'h0000_0100);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0);
    chk("t2_sum_const", 64'(out_sum), 64'h8000_0000);
    do_op(32'd7, 32'd5, 1'b1, 0, 1'b0);
    do_op(32'd5, 32'd7, 1'b1, 0, 1'b0);
    chk("t3_sum_const", 64'(out_sum), 64'hFFFF_FFFE);
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0, 1'b0);
    // Backpressure, then immediate accept of the next op on the first IDLE edge
    do_op(32'h0102_0304, 32'hF0F0_F0F0, 1'b0, 3, 1'b0);
    chk("t4_idle_ready", 64'(in_ready), 64'd1);
    do_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 0, 1'b0);
    // Operand change mid-RUN
    do_op(32'hAAAA_5555, 32'h5555_AAAB, 1'b0, 0, 1'b1);

    // Reset mid-RUN after byte 1 has been processed
    @(negedge clk);
    in_a = 32'hFFFF_FFFF; in_b = 32'h0000_0001; in_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_sum", 64'(out_sum), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 0, 1'b0);
    chk("t6_sum_const", 64'(out_sum), 64'h2345_6789);
    chk("t6_carry_const", 64'(out_carry), 64'd0);

    // Randomized operations with occasional corner operands
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 5);
      ra = $urandom;
      rb = $urandom;
      if (sel == 0) ra = 32'h7FFF_FFFF;
      if (sel == 1) rb = 32'h8000_0000;
      if (sel == 2) rb = ra;
      if (sel == 3) ra = 32'hFFFF_FFFF;
      do_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
